// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller feeding the CP0 hardware-interrupt input
module irq_ctrl #(
  parameter int          NSRC     = 6,
  parameter logic [5:0]  PEND_RST = 6'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   irq_src,
  input  logic              we,
  input  logic [4:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NSRC-1:0]   HWInt
);

  // Word selects within the window; addr[1:0] is a byte offset and carries no meaning here.
  localparam logic [2:0] SEL_PEND   = 3'd0;
  localparam logic [2:0] SEL_MASK   = 3'd1;
  localparam logic [2:0] SEL_MODE   = 3'd2;
  localparam logic [2:0] SEL_FORCE  = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;
  localparam logic [2:0] SEL_COUNT  = 3'd5;

  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] prev_src_q, prev_src_d;
  logic [31:0]     count_q, count_d;
  logic            any_q, any_d;

  logic [2:0]      sel;
  logic [NSRC-1:0] force_bits;
  logic [NSRC-1:0] clear_bits;
  logic [NSRC-1:0] set_bits;
  logic            hw_any;
  logic [2:0]      low_idx;
  logic [31:0]     status;

  // High write-data bits and the byte offset are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:NSRC], addr[1:0]};

  assign sel    = addr[4:2];
  assign HWInt  = pend_q & mask_q;
  assign hw_any = |HWInt;

  // Lowest active interrupt index and the STATUS word built from it.
  always_comb begin
    low_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (HWInt[i]) low_idx = 3'(i);
    end
    status = {hw_any, 28'd0, low_idx};
  end

  // Next-state for all controller registers, including pending-bit edge/level capture.
  always_comb begin
    force_bits = (we && sel == SEL_FORCE) ? wdata[NSRC-1:0] : '0;
    clear_bits = (we && sel == SEL_PEND)  ? wdata[NSRC-1:0] : '0;
    set_bits   = '0;
    pend_d     = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (mode_q[i]) begin
        set_bits[i] = irq_src[i] & ~prev_src_q[i];
        if (set_bits[i] || force_bits[i]) pend_d[i] = 1'b1;
        else if (clear_bits[i])           pend_d[i] = 1'b0;
      end else begin
        set_bits[i] = irq_src[i];
        pend_d[i]   = irq_src[i] | force_bits[i];
      end
    end

    mask_d = (we && sel == SEL_MASK) ? wdata[NSRC-1:0] : mask_q;
    mode_d = (we && sel == SEL_MODE) ? wdata[NSRC-1:0] : mode_q;
    prev_src_d = irq_src;
    any_d      = hw_any;

    // A software clear wins over an increment in the same cycle.
    count_d = count_q;
    if (we && sel == SEL_COUNT)  count_d = 32'd0;
    else if (hw_any && !any_q)   count_d = count_q + 32'd1;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= PEND_RST[NSRC-1:0];
      mask_q     <= '0;
      mode_q     <= '0;
      prev_src_q <= '0;
      count_q    <= 32'd0;
      any_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      prev_src_q <= prev_src_d;
      count_q    <= count_d;
      any_q      <= any_d;
    end
  end

  // Combinational read mux; reads always see the registered (pre-write) value.
  always_comb begin
    rdata = 32'd0;
    case (sel)
      SEL_PEND:   rdata = {{(32-NSRC){1'b0}}, pend_q};
      SEL_MASK:   rdata = {{(32-NSRC){1'b0}}, mask_q};
      SEL_MODE:   rdata = {{(32-NSRC){1'b0}}, mode_q};
      SEL_STATUS: rdata = status;
      SEL_COUNT:  rdata = count_q;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_src;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  HWInt;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.NSRC(6), .PEND_RST(6'b0)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [5:0]  m_pend, m_mask, m_mode, m_prev;
  logic [31:0] m_count;
  logic        m_was_any;

  function automatic logic [31:0] m_status();
    logic [5:0] act;
    int lowest;
    act = m_pend & m_mask;
    lowest = 0;
    for (int i = 5; i >= 0; i--) if (act[i]) lowest = i;
    return {(act != 6'd0), 28'd0, 3'(lowest)};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return {26'd0, m_pend};
      3'd1: return {26'd0, m_mask};
      3'd2: return {26'd0, m_mode};
      3'd4: return m_status();
      3'd5: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: compute the model's next state from current inputs, then step.
  task automatic cycle();
    logic [5:0]  np, nm, nmode, frc, w1c;
    logic [31:0] nc;
    logic        now_any;
    int          reg_no;
    reg_no  = int'(addr[4:2]);
    now_any = (m_pend & m_mask) != 6'd0;
    frc = (we && reg_no == 3) ? wdata[5:0] : 6'd0;
    w1c = (we && reg_no == 0) ? wdata[5:0] : 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (!m_mode[i])                             np[i] = irq_src[i] | frc[i];
      else if ((irq_src[i] && !m_prev[i]) || frc[i]) np[i] = 1'b1;
      else if (w1c[i])                            np[i] = 1'b0;
      else                                        np[i] = m_pend[i];
    end
    nm    = (we && reg_no == 1) ? wdata[5:0] : m_mask;
    nmode = (we && reg_no == 2) ? wdata[5:0] : m_mode;
    if (we && reg_no == 5)          nc = 32'd0;
    else if (now_any && !m_was_any) nc = m_count + 32'd1;
    else                            nc = m_count;
    @(posedge clk);
    if (reset) begin
      m_pend = 6'd0; m_mask = 6'd0; m_mode = 6'd0; m_prev = 6'd0;
      m_count = 32'd0; m_was_any = 1'b0;
    end else begin
      m_pend = np; m_mask = nm; m_mode = nmode; m_prev = irq_src;
      m_count = nc; m_was_any = now_any;
    end
    #2;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    cycle();
    we = 1'b0; addr = 5'h18; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; we = 1'b0; addr = 5'h18; wdata = 32'd0; irq_src = 6'd0;
    cycle(); cycle();
    reset = 1'b0;
    checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL reset_hwint got=%h exp=00", HWInt); end
    for (int a = 0; a < 8; a++) begin
      bus_read(5'(a * 4), d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00000000", a, d); end
      if (a == 3) cycle();
    end
    cycle();
  endtask

  task automatic test_edge_basic();
    logic [31:0] d;
    bus_write(5'h04, 32'h3F);
    bus_write(5'h08, 32'h3F);
    irq_src = 6'b000100; cycle(); irq_src = 6'd0;
    checks++; if (HWInt !== 6'b000100) begin errors++; $display("FAIL edge_hwint got=%h exp=04", HWInt); end
    bus_read(5'h10, d);
    checks++; if (d !== 32'h80000002) begin errors++; $display("FAIL edge_status got=%h exp=80000002", d); end
    cycle();
    checks++; if (HWInt !== 6'b000100) begin errors++; $display("FAIL edge_hold got=%h exp=04", HWInt); end
    bus_read(5'h14, d);
    checks++; if (d !== 32'd1 || d !== m_count) begin errors++; $display("FAIL edge_count got=%h exp=1 model=%h", d, m_count); end
    bus_write(5'h00, 32'h04);
    checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL edge_w1c got=%h exp=00", HWInt); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    bus_write(5'h08, 32'h0);
    bus_write(5'h04, 32'h01);
    irq_src = 6'b000001; cycle();
    checks++; if (HWInt !== 6'b000001) begin errors++; $display("FAIL level_set got=%h exp=01", HWInt); end
    bus_write(5'h00, 32'h01);
    checks++; if (HWInt !== 6'b000001) begin errors++; $display("FAIL level_w1c got=%h exp=01", HWInt); end
    irq_src = 6'd0; cycle();
    checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL level_drop got=%h exp=00", HWInt); end
    // Same-cycle write and read of MASK returns the old value.
    addr = 5'h04; wdata = 32'h2A; we = 1'b1; #1; d = rdata;
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL rd_during_wr got=%h exp=00000001", d); end
    cycle(); we = 1'b0;
    bus_read(5'h04, d);
    checks++; if (d !== 32'h2A) begin errors++; $display("FAIL mask_after_wr got=%h exp=0000002a", d); end
    cycle();
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    irq_src = 6'd0;
    bus_write(5'h08, 32'h3F);
    bus_write(5'h04, 32'h3F);
    bus_write(5'h00, 32'h3F);
    irq_src = 6'b000010;
    bus_write(5'h00, 32'h02);
    bus_read(5'h00, d);
    checks++; if (d[1] !== 1'b1 || d !== m_read(5'h00)) begin errors++; $display("FAIL set_beats_clear got=%h exp_bit1=1 model=%h", d, m_read(5'h00)); end
    irq_src = 6'd0;
    bus_write(5'h00, 32'h3F);
  endtask

  task automatic test_force_status();
    logic [31:0] d;
    bus_write(5'h04, 32'h0);
    bus_write(5'h0C, 32'h21);
    bus_read(5'h00, d);
    checks++; if (d !== 32'h21) begin errors++; $display("FAIL force_pend got=%h exp=00000021", d); end
    checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL force_hw0 got=%h exp=00", HWInt); end
    bus_read(5'h0C, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL force_read got=%h exp=00000000", d); end
    bus_write(5'h04, 32'h20);
    checks++; if (HWInt !== 6'h20) begin errors++; $display("FAIL force_hw20 got=%h exp=20", HWInt); end
    bus_read(5'h10, d);
    checks++; if (d[2:0] !== 3'd5 || d !== m_status()) begin errors++; $display("FAIL status5 got=%h model=%h", d, m_status()); end
    bus_write(5'h04, 32'h21);
    bus_read(5'h10, d);
    checks++; if (d[2:0] !== 3'd0 || d !== m_status()) begin errors++; $display("FAIL status0 got=%h model=%h", d, m_status()); end
    bus_write(5'h00, 32'h3F);
  endtask

  task automatic test_count_wrap();
    logic [31:0] d;
    irq_src = 6'd0;
    bus_write(5'h08, 32'h3F);
    bus_write(5'h00, 32'h3F);
    bus_write(5'h04, 32'h01);
    cycle();
    force dut.count_q = 32'hFFFFFFFF; #1; release dut.count_q;
    m_count = 32'hFFFFFFFF;
    bus_write(5'h0C, 32'h01);
    cycle();
    bus_read(5'h14, d);
    checks++; if (d !== 32'd0 || d !== m_count) begin errors++; $display("FAIL count_wrap got=%h exp=00000000", d); end
    bus_write(5'h00, 32'h01);
    cycle();
    force dut.count_q = 32'd5; #1; release dut.count_q;
    m_count = 32'd5;
    bus_write(5'h0C, 32'h01);
    bus_write(5'h14, 32'h0);
    bus_read(5'h14, d);
    checks++; if (d !== 32'd0 || d !== m_count) begin errors++; $display("FAIL count_clr_wins got=%h exp=00000000", d); end
    cycle();
    bus_read(5'h14, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL count_no_reinc got=%h exp=00000000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    irq_src = 6'd0;
    bus_write(5'h08, 32'h3F);
    bus_write(5'h04, 32'h3F);
    bus_write(5'h0C, 32'h3F);
    irq_src = 6'b001000;
    addr = 5'h04; wdata = 32'h15; we = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0; we = 1'b0;
    checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL rstmid_hw got=%h exp=00", HWInt); end
    bus_read(5'h00, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_pend got=%h exp=0", d); end
    bus_read(5'h04, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_mask got=%h exp=0", d); end
    bus_read(5'h08, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_mode got=%h exp=0", d); end
    bus_read(5'h14, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_count got=%h exp=0", d); end
    we = 1'b0;
    bus_write(5'h08, 32'h3F);
    bus_read(5'h00, d); checks++; if (d !== 32'h08) begin errors++; $display("FAIL rstmid_src3 got=%h exp=00000008", d); end
    bus_write(5'h00, 32'h08);
    cycle();
    bus_read(5'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_once got=%h exp=00000000", d); end
    irq_src = 6'd0;
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      irq_src = 6'($urandom);
      addr    = 5'($urandom);
      wdata   = $urandom;
      we      = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 63) == 0);
      #1;
      d = rdata;
      checks++;
      if (d !== m_read(addr)) begin errors++; $display("FAIL rand_rd n=%0d addr=%h got=%h exp=%h", n, addr, d, m_read(addr)); end
      checks++;
      if (HWInt !== (m_pend & m_mask)) begin errors++; $display("FAIL rand_hw n=%0d got=%h exp=%h", n, HWInt, m_pend & m_mask); end
      cycle();
    end
    reset = 1'b0; we = 1'b0;
  endtask

  initial begin
    m_pend = 6'd0; m_mask = 6'd0; m_mode = 6'd0; m_prev = 6'd0;
    m_count = 32'd0; m_was_any = 1'b0;
    reset = 1'b1; we = 1'b0; addr = 5'h18; wdata = 32'd0; irq_src = 6'd0;
    #2;
    test_reset();
    test_edge_basic();
    test_level();
    test_set_beats_clear();
    test_force_status();
    test_count_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
